// File: rtl/float_accumulator_e4m3.sv
// rtl/float_accumulator_e4m3.sv - e4m3 vector accumulator (align/add/normalise FSM, truncating)
module float_accumulator_e4m3 (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       out_ready,
    output logic [7:0] y,
    output logic       is_output_valid
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t     state, state_next;
    logic [7:0] acc;
    logic       nan_flag;
    logic [7:0] op_q;
    logic       last_q;

    logic       big_sign_q;
    logic [3:0] big_exp_q;
    logic [7:0] big_man_q;
    logic [7:0] small_man_q;
    logic       sub_q;
    logic [7:0] sum_q;

    // ALIGN: order by magnitude; exponent field 0 is treated as zero
    logic       acc_zero, op_zero, swap;
    logic [6:0] acc_mag, op_mag;
    logic [7:0] acc_man, op_man;
    logic       big_sign, small_sign;
    logic [3:0] big_exp, small_exp, exp_diff;
    logic [7:0] big_man, small_man, small_shifted;

    always_comb begin
        acc_zero  = (acc[6:3] == 4'd0);
        op_zero   = (op_q[6:3] == 4'd0);
        acc_mag   = acc_zero ? 7'd0 : acc[6:0];
        op_mag    = op_zero ? 7'd0 : op_q[6:0];
        acc_man   = acc_zero ? 8'd0 : {2'b01, acc[2:0], 3'b000};
        op_man    = op_zero ? 8'd0 : {2'b01, op_q[2:0], 3'b000};
        swap      = (op_mag > acc_mag);
        big_sign  = swap ? op_q[7] : acc[7];
        small_sign = swap ? acc[7] : op_q[7];
        big_exp   = swap ? op_mag[6:3] : acc_mag[6:3];
        small_exp = swap ? acc_mag[6:3] : op_mag[6:3];
        big_man   = swap ? op_man : acc_man;
        small_man = swap ? acc_man : op_man;
        exp_diff  = big_exp - small_exp;
        small_shifted = (exp_diff >= 4'd7) ? 8'd0 : (small_man >> exp_diff);
    end

    logic [7:0] sum_next;

    always_comb begin
        sum_next = sub_q ? (big_man_q - small_man_q) : (big_man_q + small_man_q);
    end

    // NORM: single-cycle leading-one detect over bits [6:0]
    logic [2:0] lead_pos;
    logic [2:0] lshift;
    logic [7:0] norm_man;
    logic [2:0] res_man;
    logic [5:0] res_exp;
    logic [7:0] norm_result;

    always_comb begin
        lead_pos = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (sum_q[i]) lead_pos = 3'(i);
        end
        lshift   = 3'd6 - lead_pos;
        norm_man = sum_q << lshift;
        if (sum_q[7]) begin
            res_man = sum_q[6:4];
            res_exp = {2'b00, big_exp_q} + 6'd1;
        end else begin
            res_man = norm_man[5:3];
            res_exp = {2'b00, big_exp_q} - {3'b000, lshift};
        end
        if (sum_q == 8'd0 || res_exp[5] || res_exp == 6'd0) begin
            norm_result = 8'h00;
        end else if (res_exp[4] || (res_exp[3:0] == 4'hF && res_man == 3'd7)) begin
            norm_result = {big_sign_q, 7'h7E};
        end else begin
            norm_result = {big_sign_q, res_exp[3:0], res_man};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    state_next = last_q ? DONE : IDLE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= 8'h00;
            nan_flag    <= 1'b0;
            op_q        <= 8'h00;
            last_q      <= 1'b0;
            big_sign_q  <= 1'b0;
            big_exp_q   <= 4'd0;
            big_man_q   <= 8'd0;
            small_man_q <= 8'd0;
            sub_q       <= 1'b0;
            sum_q       <= 8'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= in_data;
                        last_q <= in_last;
                        if (in_data[6:0] == 7'h7F) nan_flag <= 1'b1;
                    end
                end
                ALIGN: begin
                    big_sign_q  <= big_sign;
                    big_exp_q   <= big_exp;
                    big_man_q   <= big_man;
                    small_man_q <= small_shifted;
                    sub_q       <= big_sign ^ small_sign;
                end
                ADD: sum_q <= sum_next;
                NORM: acc <= nan_flag ? 8'h7F : norm_result;
                DONE: begin
                    if (out_ready) begin
                        acc      <= 8'h00;
                        nan_flag <= 1'b0;
                        last_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // reset gates in_ready so it is low for the whole time reset is held
    assign in_ready        = (state == IDLE) && !reset;
    assign is_output_valid = (state == DONE);
    assign y               = (state == DONE) ? acc : 8'h00;

endmodule

// File: tb/tb_float_accumulator_e4m3.sv
// tb/tb_float_accumulator_e4m3.sv - directed-vector bench for float_accumulator_e4m3
module tb_float_accumulator_e4m3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       out_ready = 1'b0;
    logic [7:0] y;
    logic       is_output_valid;

    int n_tests = 0;
    int n_fail  = 0;

    float_accumulator_e4m3 dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_ready(out_ready),
        .y(y),
        .is_output_valid(is_output_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // returns just after the accepting rising edge
    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge clock);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // counts rising edges from the accept edge (inclusive) until DONE
    task automatic wait_done(output int edges);
        edges = 1;
        while (!is_output_valid && edges < 30) begin
            @(posedge clock);
            #1;
            edges++;
        end
        if (!is_output_valid) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake(input string tag);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(is_output_valid), 32'd0);
        check({tag, "_y_zero"}, 32'(y), 32'h00);
    endtask

    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input int n, input logic [7:0] exp_y);
        int edges;
        if (n == 1) send(a, 1'b1);
        else send(a, 1'b0);
        if (n >= 2) send(b, n == 2);
        if (n >= 3) send(c, 1'b1);
        wait_done(edges);
        check({tag, "_y"}, 32'(y), 32'(exp_y));
        handshake(tag);
    endtask

    int edges;
    logic [7:0] y_hold;

    initial begin
        #2;
        check("rst_y", 32'(y), 32'h00);
        check("rst_valid", 32'(is_output_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // 1.0 + 1.0 with out_ready held high throughout
        out_ready = 1'b1;
        send(8'h38, 1'b0);
        send(8'h38, 1'b1);
        wait_done(edges);
        check("one_plus_one_y", 32'(y), 32'h40);
        check("one_plus_one_valid", 32'(is_output_valid), 32'd1);
        check("done_latency", 32'(edges), 32'd4);
        @(posedge clock);
        #1;
        check("one_plus_one_drop", 32'(is_output_valid), 32'd0);
        out_ready = 1'b0;

        run_vec("mixed", 8'h40, 8'h38, 8'hB8, 3, 8'h40);
        run_vec("cancel", 8'h38, 8'hB8, 8'h00, 2, 8'h00);
        run_vec("cancel_neg_first", 8'hB8, 8'h38, 8'h00, 2, 8'h00);
        run_vec("small_add", 8'h38, 8'h20, 8'h00, 2, 8'h39);
        run_vec("subnormal", 8'h38, 8'h05, 8'h00, 2, 8'h38);
        run_vec("sat_pos", 8'h7E, 8'h7E, 8'h00, 2, 8'h7E);
        run_vec("sat_neg", 8'hFE, 8'hFE, 8'h00, 2, 8'hFE);
        run_vec("nan", 8'h38, 8'h7F, 8'h38, 3, 8'h7F);
        run_vec("after_nan", 8'h38, 8'h00, 8'h00, 1, 8'h38);
        run_vec("underflow", 8'h09, 8'h88, 8'h00, 2, 8'h00);
        run_vec("diff7", 8'h40, 8'h08, 8'h00, 2, 8'h40);
        run_vec("diff6_trunc", 8'h38, 8'h08, 8'h00, 2, 8'h38);
        run_vec("neg_sum", 8'hB8, 8'h30, 8'h00, 2, 8'hB0);

        // in_valid asserted during ALIGN/ADD/NORM must be ignored
        send(8'h38, 1'b1);
        in_data  = 8'h7F;
        in_valid = 1'b1;
        wait_done(edges);
        in_valid = 1'b0;
        check("ignore_valid_y", 32'(y), 32'h38);
        handshake("ignore_valid");

        // backpressure in DONE
        send(8'h40, 1'b1);
        wait_done(edges);
        y_hold = y;
        check("bp_y", 32'(y_hold), 32'h40);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("bp_y_stable", 32'(y), 32'(y_hold));
            check("bp_valid_stable", 32'(is_output_valid), 32'd1);
            check("bp_ready_low", 32'(in_ready), 32'd0);
        end
        handshake("bp");
        run_vec("bp_next", 8'h38, 8'h00, 8'h00, 1, 8'h38);

        // reset during ADD aborts the vector
        send(8'h38, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_y", 32'(y), 32'h00);
        check("mid_rst_valid", 32'(is_output_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_vec("after_rst", 8'h38, 8'h00, 8'h00, 1, 8'h38);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/float_accumulator_e4m3.md
FLOAT_ACCUMULATOR_E4M3 -- requirements
Module: float_accumulator_e4m3

Interface
REQ-001 The block SHALL have no parameters; the format is fixed to e4m3: sign[7], exponent[6:3] with bias 7, mantissa[2:0].
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  8  e4m3 operand, typically a product from the e4m3 multiplier stage.
REQ-005 in_valid  input  1  in_data/in_last are valid this cycle.
REQ-006 in_last  input  1  this operand is the final one of the current vector.
REQ-007 in_ready  output  1  block will accept an operand this cycle.
REQ-008 out_ready  input  1  consumer accepts y this cycle.
REQ-009 y  output  8  e4m3 accumulated sum of the vector.
REQ-010 is_output_valid  output  1  y holds a completed sum.

Function
REQ-011 An operand SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-012 The FSM SHALL have states IDLE, ALIGN, ADD, NORM and DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE SHALL capture in_data and in_last on acceptance and go to ALIGN; otherwise it SHALL stay in IDLE.
REQ-014 ALIGN (1 cycle) SHALL order the accumulator and operand by magnitude.
REQ-015 ALIGN SHALL form 8-bit working mantissas: carry, hidden 1, 3 mantissa bits and 3 guard bits.
REQ-016 ALIGN SHALL right-shift the smaller mantissa by the exponent difference; a difference of 7 or more SHALL yield zero.
REQ-017 ADD (1 cycle) SHALL add the magnitudes if the signs match, else subtract smaller from larger; the result sign SHALL be the larger operand's sign.
REQ-018 NORM (1 cycle) SHALL normalise with a single-cycle leading-one detect: right-shift 1 on carry, otherwise left-shift up to 6.
REQ-019 NORM SHALL truncate (round toward zero) to 3 mantissa bits and write the accumulator.
REQ-020 NORM SHALL go to DONE if the captured in_last was 1, else to IDLE.
REQ-021 Sustained throughput SHALL be one operand per 4 cycles (IDLE, ALIGN, ADD, NORM).
REQ-022 An input with exponent field 0 SHALL be treated as zero (subnormals flushed).
REQ-023 A result with exponent below 1 SHALL flush to +0 (0x00).
REQ-024 A zero magnitude result, including exact cancellation, SHALL be +0.
REQ-025 A result above 448 SHALL saturate to S.1111.110 (0x7E or 0xFE), keeping the result sign.
REQ-026 Input 0x7F or 0xFF (NaN) SHALL set a sticky NaN flag; the vector result SHALL then be 0x7F regardless of later operands.
REQ-027 In DONE, is_output_valid SHALL be 1 and y SHALL equal the accumulator, held stable until out_ready is 1.
REQ-028 On the DONE handshake edge, the accumulator and NaN flag SHALL clear to 0 and the FSM SHALL go to IDLE; is_output_valid SHALL be 0 the next cycle.
REQ-029 Outside DONE, is_output_valid SHALL be 0 and y SHALL be 0x00.
REQ-030 in_valid in any non-IDLE state SHALL be ignored and SHALL NOT corrupt the computation in progress.
REQ-031 out_ready outside DONE SHALL be ignored.

Reset
REQ-032 While reset is 1, the FSM SHALL be IDLE, the accumulator, NaN flag and captured operand 0, y=0x00, is_output_valid=0 and in_ready=0.
REQ-033 On reset deassertion, in_ready SHALL be 1 from the first cycle in IDLE.
REQ-034 Reset asserted in any state, including mid-vector or in DONE, SHALL abort the vector with no output produced.

Verification
REQ-035 1.0+1.0: 0x38, then 0x38 with last, out_ready=1 -> y=0x40 with is_output_valid; DONE entered 4 cycles after the last accept.
REQ-036 Mixed signs: 0x40, 0x38, 0xB8(last) -> y=0x40; and 0x38, 0xB8(last) -> y=0x00 (+0).
REQ-037 Small addend and flush: 0x38, 0x20(last) -> y=0x39; 0x38, 0x05(last), a subnormal -> y=0x38.
REQ-038 Saturation and NaN: 0x7E, 0x7E(last) -> y=0x7E; 0x38, 0x7F, 0x38(last) -> y=0x7F.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in DONE -> y and is_output_valid are stable and in_ready=0; the next vector starts from acc=0 after the handshake.
REQ-040 Reset mid-vector: assert reset during ADD -> outputs return to reset values at once; a new vector of 0x38(last) gives y=0x38.
